dcache_param: RTL

- Parametrised write-back, write-allocate, set-associative data cache.
- Sits between the datapath's data-memory port and the memory/bus controller.
- Generalises set count, associativity and block size. Uses true LRU replacement across any way count.
- Flush skips clean lines. On halt it writes both hit and miss statistics to memory before asserting flushed.

---
 rtl/cpu_types_pkg.sv | 4 +
 rtl/dcache_param_pkg.sv | 17 +
 rtl/dcache_param_if.sv | 28 ++
 rtl/dcache_lru.sv | 38 +++
 rtl/dcache_param.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/dcache_param_pkg.sv
// dcache_param_pkg: cache state enum, default geometry and the default-geometry line layout
package dcache_param_pkg;
  import cpu_types_pkg::*;
  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, STAT0, STAT1, HALTED} dcache_state_t;
  localparam int SETS_D = 8;
  localparam int WAYS_D = 2;
  localparam int WORDS_D = 2;
  localparam int WOFF = $clog2(WORDS_D);
  localparam int IDX = $clog2(SETS_D);
  localparam int TAGW = 32 - 2 - WOFF - IDX;
  typedef struct packed {
    logic [TAGW-1:0] tag;
    word_t [WORDS_D-1:0] data;
    logic valid;
    logic dirty;
  } line_t;
endpackage

// File: rtl/dcache_param_if.sv
// dcache_param_if: datapath-side and memory-side buses of the data cache
//   dcache_dp_if  : master = datapath, slave = cache (halt, requests, address, store/load data, dhit, flushed)
//   dcache_mem_if : master = cache, slave = memory controller (dREN/dWEN, daddr, dstore, dload, dwait)
interface dcache_dp_if;
  import cpu_types_pkg::*;
  logic halt;
  logic dmemREN;
  logic dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic dhit;
  word_t dmemload;
  logic flushed;
  modport master (output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, input dhit, dmemload, flushed);
  modport slave (input halt, dmemREN, dmemWEN, dmemaddr, dmemstore, output dhit, dmemload, flushed);
endinterface

interface dcache_mem_if;
  import cpu_types_pkg::*;
  logic dREN;
  logic dWEN;
  word_t daddr;
  word_t dstore;
  word_t dload;
  logic dwait;
  modport master (output dREN, dWEN, daddr, dstore, input dload, dwait);
  modport slave (input dREN, dWEN, daddr, dstore, output dload, dwait);
endinterface

// File: rtl/dcache_lru.sv
// dcache_lru: per-set true-LRU age counters
//   CLK, nRST           : clock, asynchronous active-low reset
//   touch/touch_set/way : mark (set, way) most recently used
//   vic_set -> vic_way  : way whose age is WAYS-1 in vic_set
module dcache_lru #(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    touch,
  input  logic [$clog2(SETS)-1:0] touch_set,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  input  logic [$clog2(SETS)-1:0] vic_set,
  output logic [$clog2(WAYS)-1:0] vic_way
);
  localparam int AW = $clog2(WAYS);
  logic [AW-1:0] age [SETS][WAYS];
  logic [AW-1:0] old;
  assign old = age[touch_set][touch_way];
  // ages within a set always form a permutation of 0..WAYS-1
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= AW'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++)
        age[touch_set][w] <= (AW'(w) == touch_way) ? '0 :
                             (age[touch_set][w] < old) ? age[touch_set][w] + AW'(1) : age[touch_set][w];
    end
  end
  always_comb begin
    vic_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[vic_set][w] == AW'(WAYS-1)) vic_way = AW'(w);
  end
endmodule

// File: rtl/dcache_param.sv
// dcache_param: write-back, write-allocate, set-associative data cache with flush and hit/miss statistics
//   CLK, nRST : clock, asynchronous active-low reset
//   dp        : datapath port (halt, dmemREN/WEN, dmemaddr, dmemstore -> dhit, dmemload, flushed)
//   mem       : memory port (dREN/dWEN, daddr, dstore -> dload, dwait)
module dcache_param
  import cpu_types_pkg::*;
  import dcache_param_pkg::*;
#(
  parameter int    SETS      = 8,
  parameter int    WAYS      = 2,
  parameter int    WORDS     = 2,
  parameter word_t STAT_ADDR = 32'h3100
) (
  input logic          CLK,
  input logic          nRST,
  dcache_dp_if.slave   dp,
  dcache_mem_if.master mem
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(SETS);
  localparam int AW = $clog2(WAYS);
  localparam int TW = 32 - 2 - OW - IW;
  logic [TW-1:0] tag_q [SETS][WAYS];
  word_t data_q [SETS][WAYS][WORDS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  dcache_state_t state, state_n;
  logic [OW-1:0] beat;
  logic [IW-1:0] fset, ridx;
  logic [AW-1:0] fway, vway;
  logic [TW-1:0] rtag;
  word_t hitcount, misscount;
  logic first;
  logic [OW-1:0] a_off;
  logic [IW-1:0] a_idx;
  logic [TW-1:0] a_tag;
  logic hit_any, inv_any, hit, miss, req, last, fdirty, flast, beat_go, fill_done, fadv;
  logic [AW-1:0] hit_way, inv_way, lru_way, vic;
  assign a_off = dp.dmemaddr[2 +: OW];
  assign a_idx = dp.dmemaddr[2+OW +: IW];
  assign a_tag = dp.dmemaddr[31 -: TW];
  // descending scan leaves the lowest-index invalid way in inv_way
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[a_idx][w] && tag_q[a_idx][w] == a_tag) begin
        hit_any = 1'b1;
        hit_way = AW'(w);
      end
      if (!valid_q[a_idx][w]) begin
        inv_any = 1'b1;
        inv_way = AW'(w);
      end
    end
  end
  assign req = dp.dmemREN | dp.dmemWEN;
  assign hit = req & (state == IDLE) & !dp.halt & hit_any;
  assign miss = req & (state == IDLE) & !dp.halt & !hit_any;
  assign vic = inv_any ? inv_way : lru_way;
  assign dp.dhit = hit;
  assign dp.dmemload = hit ? data_q[a_idx][hit_way][a_off] : '0;
  assign last = beat == OW'(WORDS-1);
  assign fdirty = valid_q[fset][fway] & dirty_q[fset][fway];
  assign flast = (fset == IW'(SETS-1)) && (fway == AW'(WAYS-1));
  assign beat_go = !mem.dwait && (state == WB || state == FETCH || (state == FLUSH && fdirty));
  assign fill_done = state == FETCH && !mem.dwait && last;
  // clean or invalid lines are stepped over in a single cycle
  assign fadv = state == FLUSH && (!fdirty || (!mem.dwait && last));
  dcache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .CLK       (CLK),
    .nRST      (nRST),
    .touch     (hit | fill_done),
    .touch_set (hit ? a_idx : ridx),
    .touch_way (hit ? hit_way : vway),
    .vic_set   (a_idx),
    .vic_way   (lru_way)
  );
  always_comb begin
    state_n = state;
    mem.dREN = 1'b0;
    mem.dWEN = 1'b0;
    mem.daddr = '0;
    mem.dstore = '0;
    dp.flushed = 1'b0;
    case (state)
      IDLE: state_n = dp.halt ? FLUSH :
                      miss ? ((valid_q[a_idx][vic] && dirty_q[a_idx][vic]) ? WB : FETCH) : IDLE;
      WB: begin
        mem.dWEN = 1'b1;
        mem.daddr = {tag_q[ridx][vway], ridx, beat, 2'b00};
        mem.dstore = data_q[ridx][vway][beat];
        state_n = (!mem.dwait && last) ? FETCH : WB;
      end
      FETCH: begin
        mem.dREN = 1'b1;
        mem.daddr = {rtag, ridx, beat, 2'b00};
        state_n = fill_done ? IDLE : FETCH;
      end
      FLUSH: begin
        mem.dWEN = fdirty;
        mem.daddr = fdirty ? {tag_q[fset][fway], fset, beat, 2'b00} : '0;
        mem.dstore = fdirty ? data_q[fset][fway][beat] : '0;
        state_n = (fadv && flast) ? STAT0 : FLUSH;
      end
      STAT0: begin
        mem.dWEN = 1'b1;
        mem.daddr = STAT_ADDR;
        mem.dstore = hitcount;
        state_n = mem.dwait ? STAT0 : STAT1;
      end
      STAT1: begin
        mem.dWEN = 1'b1;
        mem.daddr = STAT_ADDR + 32'd4;
        mem.dstore = misscount;
        state_n = mem.dwait ? STAT1 : HALTED;
      end
      HALTED: dp.flushed = 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      beat <= '0;
      fset <= '0;
      fway <= '0;
      ridx <= '0;
      vway <= '0;
      rtag <= '0;
      hitcount <= '0;
      misscount <= '0;
      first <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state <= state_n;
      if (beat_go) beat <= beat + OW'(1);
      if (miss) begin
        ridx <= a_idx;
        rtag <= a_tag;
        vway <= vic;
      end
      // the dhit that completes a just-filled miss is not counted as a hit
      if (hit) begin
        first <= 1'b0;
        hitcount <= first ? hitcount : hitcount + 32'd1;
      end
      if (hit && dp.dmemWEN) dirty_q[a_idx][hit_way] <= 1'b1;
      if (fill_done) begin
        valid_q[ridx][vway] <= 1'b1;
        dirty_q[ridx][vway] <= 1'b0;
        misscount <= misscount + 32'd1;
        first <= 1'b1;
      end
      if (fadv) begin
        dirty_q[fset][fway] <= 1'b0;
        fway <= fway + AW'(1);
        if (fway == AW'(WAYS-1)) fset <= fset + IW'(1);
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (hit && dp.dmemWEN) data_q[a_idx][hit_way][a_off] <= dp.dmemstore;
    if (state == FETCH && !mem.dwait) data_q[ridx][vway][beat] <= mem.dload;
    if (fill_done) tag_q[ridx][vway] <= rtag;
  end
endmodule
